hc_595_rx: RTL and testbench

- Serial-side receiver and checker for the 74HC595 display chain.
- Samples the ds/shcp/stcp/oe pin set produced by the display driver, in the sys_clk domain.
- Rebuilds the 14-bit frame and presents the latched digit-select and segment bytes that a pair of cascaded 595s would drive.
- Used for loopback self-check on board and as a bit-accurate checker in simulation; flags malformed frames.

---
 rtl/hc_595_rx.sv | 193 +++++++++++++++++++
 tb/tb_hc_595_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_595_rx.sv
// hc_595_rx: receiver/checker for a 74HC595 display chain (6-bit digit select + 8-bit segments).
// Samples ds/shcp/stcp/oe in the sys_clk domain, rebuilds the 14-bit frame and
// presents the latched sel/seg, flagging short, long and timed-out frames.
// Optional macro HC595_RX_DECODE_EN adds a common-anode digit decode (digit, dp, digit_ok).
module hc_595_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ds,
    input  logic       shcp,
    input  logic       stcp,
    input  logic       oe,
    output logic [5:0] sel,
    output logic [7:0] seg,
    output logic       frame_valid,
    output logic       bit_err,
    output logic       disp_on
`ifdef HC595_RX_DECODE_EN
    ,
    output logic [4:0] digit,
    output logic       dp,
    output logic       digit_ok
`endif
);

    localparam int unsigned PW    = 4;                     // pins: {oe, stcp, shcp, ds}
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC);
    localparam int unsigned FBITS = 14;

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic [1:0]       edge_q, edge_d;                      // previous {stcp, shcp}
    logic [FBITS-1:0] sr_q, sr_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             go_q, go_d;                          // good latch decided, apply next edge
    logic             bad_q, bad_d;                        // rejected latch decided
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;
    logic             disp_q, disp_d;

    logic             ds_s, shcp_s, stcp_s, oe_s;
    logic             shcp_rise, stcp_rise, tmo_hit;
    logic [3:0]       cnt_after;

    assign ds_s   = sync_q[SYNC_STAGES-1][0];
    assign shcp_s = sync_q[SYNC_STAGES-1][1];
    assign stcp_s = sync_q[SYNC_STAGES-1][2];
    assign oe_s   = sync_q[SYNC_STAGES-1][3];

`ifdef HC595_RX_DECODE_EN
    logic [4:0] digit_q, digit_d;
    logic       dp_q, dp_d;
    logic       ok_q, ok_d;

    // Common-anode 7-segment decode; returns {match, code}
    function automatic logic [5:0] decode7(input logic [6:0] s);
        logic [5:0] r;
        r = {1'b0, 5'h1F};
        case ({1'b1, s})
            8'hC0: r = {1'b1, 5'h00};
            8'hF9: r = {1'b1, 5'h01};
            8'hA4: r = {1'b1, 5'h02};
            8'hB0: r = {1'b1, 5'h03};
            8'h99: r = {1'b1, 5'h04};
            8'h92: r = {1'b1, 5'h05};
            8'h82: r = {1'b1, 5'h06};
            8'hF8: r = {1'b1, 5'h07};
            8'h80: r = {1'b1, 5'h08};
            8'h90: r = {1'b1, 5'h09};
            8'h88: r = {1'b1, 5'h0A};
            8'h83: r = {1'b1, 5'h0B};
            8'hC6: r = {1'b1, 5'h0C};
            8'hA1: r = {1'b1, 5'h0D};
            8'h86: r = {1'b1, 5'h0E};
            8'h8E: r = {1'b1, 5'h0F};
            8'hBF: r = {1'b1, 5'h10};
            8'hFF: r = {1'b1, 5'h11};
            default: r = {1'b0, 5'h1F};
        endcase
        return r;
    endfunction
`endif

    // Next-state: synchronise, shift, latch decision, timeout and output update
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], {oe, stcp, shcp, ds}};
        edge_d    = {stcp_s, shcp_s};
        shcp_rise = shcp_s & ~edge_q[0];
        stcp_rise = stcp_s & ~edge_q[1];

        sr_d      = sr_q;
        cnt_after = bit_cnt_q;
        if (shcp_rise) begin
            sr_d = {sr_q[FBITS-2:0], ds_s};
            if (bit_cnt_q != 4'd15) begin
                cnt_after = bit_cnt_q + 4'd1;
            end
        end

        // A coincident shift or latch takes precedence over an expiring timeout
        tmo_hit = (bit_cnt_q != 4'd0) && !shcp_rise && !stcp_rise &&
                  (tmo_q == TW'(TIMEOUT_CYC - 1));

        bit_cnt_d = cnt_after;
        if (stcp_rise || tmo_hit) begin
            bit_cnt_d = 4'd0;
        end

        tmo_d = tmo_q + TW'(1);
        if (shcp_rise || (bit_cnt_d == 4'd0)) begin
            tmo_d = '0;
        end

        go_d  = stcp_rise && (cnt_after == 4'd14);
        bad_d = stcp_rise && (cnt_after != 4'd14);

        // sr_q still holds the frame captured on the deciding edge
        sel_d = sel_q;
        seg_d = seg_q;
        if (go_q) begin
            for (int i = 0; i < 6; i++) begin
                sel_d[i] = sr_q[13-i];
            end
            seg_d = sr_q[7:0];
        end

        fv_d   = go_q;
        err_d  = bad_q || tmo_hit;
        disp_d = ~oe_s;

`ifdef HC595_RX_DECODE_EN
        {ok_d, digit_d} = decode7(seg_d[6:0]);
        dp_d            = ~seg_d[7];
`endif
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q    <= '0;
            edge_q    <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            go_q      <= 1'b0;
            bad_q     <= 1'b0;
            sel_q     <= 6'h00;
            seg_q     <= 8'hFF;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            disp_q    <= 1'b0;
`ifdef HC595_RX_DECODE_EN
            digit_q   <= 5'h11;
            dp_q      <= 1'b0;
            ok_q      <= 1'b1;
`endif
        end else begin
            sync_q    <= sync_d;
            edge_q    <= edge_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            go_q      <= go_d;
            bad_q     <= bad_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            disp_q    <= disp_d;
`ifdef HC595_RX_DECODE_EN
            digit_q   <= digit_d;
            dp_q      <= dp_d;
            ok_q      <= ok_d;
`endif
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign frame_valid = fv_q;
    assign bit_err     = err_q;
    assign disp_on     = disp_q;
`ifdef HC595_RX_DECODE_EN
    assign digit       = digit_q;
    assign dp          = dp_q;
    assign digit_ok    = ok_q;
`endif

endmodule

// File: tb/tb_hc_595_rx.sv
// Scoreboard bench for hc_595_rx: directed frames push expectations, a monitor pops on each pulse.
module tb_hc_595_rx;

    localparam int unsigned S   = 2;
    localparam int unsigned TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ds, shcp, stcp, oe;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       frame_valid, bit_err, disp_on;
`ifdef HC595_RX_DECODE_EN
    logic [4:0] digit;
    logic       dp, digit_ok;
`endif

    hc_595_rx #(.SYNC_STAGES(S), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .oe          (oe),
        .sel         (sel),
        .seg         (seg),
        .frame_valid (frame_valid),
        .bit_err     (bit_err),
        .disp_on     (disp_on)
`ifdef HC595_RX_DECODE_EN
        ,
        .digit       (digit),
        .dp          (dp),
        .digit_ok    (digit_ok)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       err;
        logic [5:0] sel;
        logic [7:0] seg;
        logic [4:0] dig;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] cur_sel = 6'h00;
    logic [7:0] cur_seg = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: every frame_valid/bit_err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (frame_valid || bit_err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse fv=%0b err=%0b sel=%0h seg=%0h",
                         frame_valid, bit_err, sel, seg);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (frame_valid !== !e.err || bit_err !== e.err || sel !== e.sel || seg !== e.seg) begin
                    errors++;
                    $display("FAIL sb_pulse act fv=%0b err=%0b sel=%0h seg=%0h exp err=%0b sel=%0h seg=%0h",
                             frame_valid, bit_err, sel, seg, e.err, e.sel, e.seg);
                end
`ifdef HC595_RX_DECODE_EN
                else if (!e.err && (digit !== e.dig || dp !== ~e.seg[7] || digit_ok !== 1'b1)) begin
                    errors++;
                    $display("FAIL sb_decode act digit=%0h dp=%0b ok=%0b exp digit=%0h dp=%0b ok=1",
                             digit, dp, digit_ok, e.dig, ~e.seg[7]);
                end
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] fbits(input logic [5:0] s, input logic [7:0] g);
        logic [13:0] b;
        for (int i = 0; i < 6; i++) b[i] = s[i];
        for (int j = 0; j < 8; j++) b[6+j] = g[7-j];
        return b;
    endfunction

    task automatic send_bit(input logic b);
        ds   = b;
        shcp = 1'b0;
        tick(2);
        shcp = 1'b1;
        tick(2);
    endtask

    task automatic send_bits(input logic [5:0] s, input logic [7:0] g, input int n);
        logic [13:0] b;
        b = fbits(s, g);
        for (int k = 0; k < n; k++) send_bit((k < 14) ? b[k] : 1'b1);
    endtask

    task automatic push(input logic err, input logic [5:0] s, input logic [7:0] g, input logic [4:0] d);
        exp_t e;
        e.err = err; e.sel = s; e.seg = g; e.dig = d;
        sb.push_back(e);
        if (!err) begin
            cur_sel = s;
            cur_seg = g;
        end
    endtask

    task automatic pulse_stcp();
        stcp = 1'b1;
        tick(2);
        stcp = 1'b0;
        tick(2);
    endtask

    // Bounded wait for all expected pulses, then a quiet gap to catch extra ones
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
        tick(6);
    endtask

    task automatic good_frame(input logic [5:0] s, input logic [7:0] g, input logic [4:0] d, input string name);
        send_bits(s, g, 14);
        push(1'b0, s, g, d);
        pulse_stcp();
        drain(name);
    endtask

    task automatic bad_frame(input int n, input string name);
        send_bits(6'h15, 8'h55, n);
        push(1'b1, cur_sel, cur_seg, 5'h00);
        pulse_stcp();
        drain(name);
    endtask

    initial begin
        int lat;
        logic [13:0] b;
        rst_n = 1'b0;
        ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        tick(3);
        chk("rst_sel", sel, 6'h00);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", bit_err, 0);
        chk("rst_disp", disp_on, 0);
        rst_n = 1'b1;
        tick(4);

        good_frame(6'h01, 8'hC0, 5'h00, "good_c0");
        bad_frame(13, "short");
        chk("short_hold_sel", sel, 6'h01);
        chk("short_hold_seg", seg, 8'hC0);
        good_frame(6'h20, 8'h80, 5'h08, "good_80");
        bad_frame(16, "long");
        good_frame(6'h05, 8'hA4, 5'h02, "after_long");
        bad_frame(0, "empty_latch");
        good_frame(6'h3F, 8'h12, 5'h05, "dp_92");

        // Timeout after a 7-bit partial frame
        send_bits(6'h2A, 8'h33, 7);
        push(1'b1, cur_sel, cur_seg, 5'h00);
        lat = 0;
        for (int c = 1; c <= int'(TMO) + 5; c++) begin
            tick(1);
            if (bit_err && lat == 0) lat = c;
        end
        chk("tmo_latency", lat, TMO + S - 1);
        drain("tmo_sb");
        good_frame(6'h12, 8'hF9, 5'h01, "after_tmo");

        // Output enable follows inverted after S+1 edges
        oe = 1'b0;
        tick(S);
        chk("oe_low_early", disp_on, 0);
        tick(1);
        chk("oe_low", disp_on, 1);
        oe = 1'b1;
        tick(S);
        chk("oe_high_early", disp_on, 1);
        tick(1);
        chk("oe_high", disp_on, 0);

        // Reset mid-frame: outputs clear immediately, no error pulse
        send_bits(6'h3C, 8'h86, 9);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", sel, 6'h00);
        chk("midrst_seg", seg, 8'hFF);
        shcp = 1'b0;
        tick(3);
        rst_n = 1'b1;
        cur_sel = 6'h00;
        cur_seg = 8'hFF;
        tick(4);
        good_frame(6'h2A, 8'h8E, 5'h0F, "after_rst");

        // Coincident 14th shcp rise and stcp rise
        b = fbits(6'h0C, 8'hC6);
        for (int k = 0; k < 13; k++) send_bit(b[k]);
        ds   = b[13];
        shcp = 1'b0;
        tick(2);
        push(1'b0, 6'h0C, 8'hC6, 5'h0C);
        shcp = 1'b1;
        stcp = 1'b1;
        tick(2);
        shcp = 1'b0;
        stcp = 1'b0;
        tick(2);
        drain("coincident");
        good_frame(6'h30, 8'hBF, 5'h10, "minus");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
